switch_debounce: RTL

//  Per-bit debouncer and edge detector for the 10 slide-switch/key inputs.
//  It consumes the 2-FF synchronizer output, so every input is already in the clk domain.

---
 rtl/switch_debounce_if.sv | 27 ++
 rtl/switch_debounce.sv | 65 ++++++
 2 files changed

// File: rtl/switch_debounce_if.sv
// Switch debouncer signal bundle: synchronized inputs in, debounced levels and strobes out.
// master drives sync_in (upstream/consumer side); slave is the debouncer itself.
interface switch_debounce_if #(
   parameter int unsigned WIDTH = 10
);
   logic [WIDTH-1:0] sync_in;
   logic [WIDTH-1:0] db_out;
   logic [WIDTH-1:0] rise_pulse;
   logic [WIDTH-1:0] fall_pulse;
   logic             any_change;

   modport master (
      output sync_in,
      input  db_out,
      input  rise_pulse,
      input  fall_pulse,
      input  any_change
   );

   modport slave (
      input  sync_in,
      output db_out,
      output rise_pulse,
      output fall_pulse,
      output any_change
   );
endinterface

// File: rtl/switch_debounce.sv
// Per-bit debouncer with registered level, single-cycle rise/fall strobes and a combined
// change flag; each bit accepts a new level after DEBOUNCE_CYCLES consecutive differing samples.
module switch_debounce #(
   parameter int unsigned WIDTH           = 10,
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input logic               clk,
   input logic               rst,
   switch_debounce_if.slave  bus
);
   localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic [WIDTH-1:0] db_q, db_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic             any_q, any_d;

   always_comb begin
      db_d   = db_q;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         cnt_d[i] = '0;
         if (bus.sync_in[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               // Last of the required consecutive samples: accept and strobe.
               db_d[i]   = bus.sync_in[i];
               rise_d[i] = bus.sync_in[i];
               fall_d[i] = ~bus.sync_in[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
      any_d = (|rise_d) | (|fall_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         db_q   <= '0;
         rise_q <= '0;
         fall_q <= '0;
         any_q  <= 1'b0;
         for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         db_q   <= db_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         any_q  <= any_d;
         for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign bus.db_out     = db_q;
   assign bus.rise_pulse = rise_q;
   assign bus.fall_pulse = fall_q;
   assign bus.any_change = any_q;
endmodule
